// File: rtl/step_debug_ctrl.sv
// Debug step controller: sync/debounce of a raw step key, free-run step timer, step counter and freezable hex display.
// Latency: key press to StepEn = FILTER_CYCLES+1 cycles; StepEn/StepCount/Digits are all registered.
module step_debug_ctrl #(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 8,
  parameter int DIGITS        = 8,
  parameter int FILTER_CYCLES = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          StepKey,
  input  logic                          RunMode,
  input  logic [15:0]                   RunPeriod,
  input  logic [$clog2(CHANNELS)-1:0]   Sel,
  input  logic                          Freeze,
  input  logic [CHANNELS*WIDTH-1:0]     ChanData,
  output logic                          StepEn,
  output logic [15:0]                   StepCount,
  output logic [DIGITS*4-1:0]           Digits
);

  localparam int DW = $clog2(FILTER_CYCLES);

  logic             sync1, sync2, filt;
  logic [DW-1:0]    dcnt;
  logic [15:0]      pcnt, period_m1;
  logic             key_accept, key_press, run_fire;
  logic [WIDTH-1:0] disp, chan_sel;

  always_comb begin
    period_m1  = (RunPeriod == 16'd0) ? 16'd0 : RunPeriod - 16'd1;
    key_accept = (sync2 != filt) && (dcnt == DW'(FILTER_CYCLES - 1));
    // filt is still 1 here, so an accepted change is a press
    key_press  = key_accept && filt;
    // >= so that shrinking RunPeriod mid-count fires on the next edge
    run_fire   = RunMode && (pcnt >= period_m1);
    chan_sel   = '0;
    if (32'(Sel) < CHANNELS) chan_sel = ChanData[Sel*WIDTH +: WIDTH];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      filt      <= 1'b1;
      dcnt      <= '0;
      pcnt      <= '0;
      StepEn    <= 1'b0;
      StepCount <= '0;
      disp      <= '0;
    end else begin
      sync1 <= StepKey;
      sync2 <= sync1;

      if (sync2 == filt) begin
        dcnt <= '0;
      end else if (key_accept) begin
        filt <= sync2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end

      if (!RunMode || run_fire) pcnt <= '0;
      else                      pcnt <= pcnt + 16'd1;

      StepEn    <= RunMode ? run_fire : key_press;
      StepCount <= StepCount + {15'd0, StepEn};

      if (!Freeze) disp <= chan_sel;
    end
  end

  // Nibbles past WIDTH read as zero; a partial top nibble is zero-extended
  for (genvar k = 0; k < DIGITS; k++) begin : g_nib
    if (4*k + 4 <= WIDTH) begin : g_full
      assign Digits[4*k +: 4] = disp[4*k +: 4];
    end else if (4*k < WIDTH) begin : g_part
      assign Digits[4*k +: 4] = 4'(disp[WIDTH-1:4*k]);
    end else begin : g_zero
      assign Digits[4*k +: 4] = 4'd0;
    end
  end

endmodule

// File: tb/tb_step_debug_ctrl.sv
// Bench for step_debug_ctrl (FILTER_CYCLES=4): directed scenarios plus randomized traffic against a window/timestamp model.
module tb_step_debug_ctrl;

  localparam int F = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         StepKey = 1'b1;
  logic         RunMode = 1'b0;
  logic [15:0]  RunPeriod = 16'd1;
  logic [2:0]   Sel = 3'd0;
  logic         Freeze = 1'b0;
  logic [127:0] ChanData = '0;
  logic         StepEn;
  logic [15:0]  StepCount;
  logic [31:0]  Digits;

  int tests = 0;
  int fails = 0;

  step_debug_ctrl #(.WIDTH(16), .CHANNELS(8), .DIGITS(8), .FILTER_CYCLES(F)) dut (
    .Clock(Clock), .Reset(Reset), .StepKey(StepKey), .RunMode(RunMode),
    .RunPeriod(RunPeriod), .Sel(Sel), .Freeze(Freeze), .ChanData(ChanData),
    .StepEn(StepEn), .StepCount(StepCount), .Digits(Digits)
  );

  always #5 Clock = ~Clock;

  // Reference model: key history window, free-run timestamps, plain counters
  bit        hist [0:F];
  bit        m_filt = 1'b1;
  int        ecount = 0;
  int        m_anchor = 0;
  bit        m_step = 1'b0;
  int        m_count = 0;
  logic [15:0] m_disp = '0;

  task automatic tick();
    bit flip;
    bit stepn;
    int p;
    p = (RunPeriod == 16'd0) ? 1 : int'(RunPeriod);
    if (Reset) begin
      for (int i = 0; i <= F; i++) hist[i] = 1'b1;
      m_filt = 1'b1; m_anchor = ecount; m_step = 1'b0; m_count = 0; m_disp = '0;
    end else begin
      m_count = (m_count + int'(m_step)) & 16'hFFFF;
      // level accepted once the last F synchronised samples all disagree with it
      flip = 1'b1;
      for (int i = 1; i <= F; i++) if (hist[i] == m_filt) flip = 1'b0;
      stepn = 1'b0;
      if (RunMode) begin
        if (ecount - m_anchor >= p) begin stepn = 1'b1; m_anchor = ecount; end
      end else begin
        m_anchor = ecount;
        if (flip && m_filt) stepn = 1'b1;
      end
      if (flip) m_filt = ~m_filt;
      for (int i = F; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = StepKey;
      m_step = stepn;
      if (!Freeze) m_disp = ChanData[Sel*16 +: 16];
    end
    @(posedge Clock);
    ecount++;
    #1;
  endtask

  task automatic test_reset();
    ChanData = {8{16'hA5A5}};
    Reset = 1'b1;
    tick(); tick();
    tests++; if (StepEn !== 1'b0) begin fails++; $display("FAIL reset_stepen got %0b want 0", StepEn); end
    tests++; if (StepCount !== 16'd0) begin fails++; $display("FAIL reset_count got %h want 0000", StepCount); end
    tests++; if (Digits !== 32'd0) begin fails++; $display("FAIL reset_digits got %h want 00000000", Digits); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    int pulses = 0;
    StepKey = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(StepEn); end
    StepKey = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); pulses += int'(StepEn); end
    tests++; if (pulses != 0) begin fails++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    tests++; if (StepCount !== 16'd0) begin fails++; $display("FAIL glitch_count got %h want 0000", StepCount); end
  endtask

  task automatic test_single_step();
    int pulses = 0;
    int at = -1;
    StepKey = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (StepEn === 1'b1) begin pulses++; at = k; end
      tests++; if (StepEn !== m_step) begin fails++; $display("FAIL step_model k=%0d got %0b want %0b", k, StepEn, m_step); end
    end
    tests++; if (pulses != 1 || at != F + 2) begin fails++; $display("FAIL step_once pulses=%0d at=%0d want 1 at %0d", pulses, at, F + 2); end
    StepKey = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin tick(); pulses += int'(StepEn); end
    tests++; if (pulses != 0) begin fails++; $display("FAIL release_pulses got %0d want 0", pulses); end
    tests++; if (StepCount !== 16'd1) begin fails++; $display("FAIL step_count got %h want 0001", StepCount); end
  endtask

  task automatic test_free_run();
    int base;
    base = m_count;
    RunMode = 1'b1; RunPeriod = 16'd3;
    for (int k = 1; k <= 13; k++) begin
      tick();
      tests++; if (StepEn !== ((k % 3) == 0)) begin fails++; $display("FAIL run3 k=%0d got %0b want %0b", k, StepEn, (k % 3) == 0); end
    end
    tests++; if (StepCount !== 16'(base + 4)) begin fails++; $display("FAIL run3_count got %h want %h", StepCount, 16'(base + 4)); end
    RunPeriod = 16'd0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests++; if (StepEn !== 1'b1) begin fails++; $display("FAIL run0 k=%0d got %0b want 1", k, StepEn); end
    end
    RunMode = 1'b0;
    tick(); tick();
  endtask

  task automatic test_display();
    ChanData = '0;
    ChanData[5*16 +: 16] = 16'hBEEF;
    ChanData[7*16 +: 16] = 16'h7777;
    Sel = 3'd5; Freeze = 1'b0;
    tick();
    tests++; if (Digits !== 32'h0000BEEF) begin fails++; $display("FAIL disp_load got %h want 0000beef", Digits); end
    Freeze = 1'b1;
    ChanData[5*16 +: 16] = 16'h1234;
    tick();
    tests++; if (Digits !== 32'h0000BEEF) begin fails++; $display("FAIL disp_freeze got %h want 0000beef", Digits); end
    Sel = 3'd7;
    tick();
    tests++; if (Digits !== 32'h0000BEEF) begin fails++; $display("FAIL disp_sel_frozen got %h want 0000beef", Digits); end
    Freeze = 1'b0;
    tick();
    tests++; if (Digits !== 32'h00007777) begin fails++; $display("FAIL disp_unfreeze got %h want 00007777", Digits); end
  endtask

  task automatic test_wrap();
    int n = 0;
    RunMode = 1'b1; RunPeriod = 16'd0;
    while (m_count != 16'hFFFF && n < 70000) begin tick(); n++; end
    tests++; if (n >= 70000) begin fails++; $display("FAIL wrap_timeout got n=%0d want <70000", n); end
    tests++; if (StepCount !== 16'hFFFF) begin fails++; $display("FAIL wrap_full got %h want ffff", StepCount); end
    tick();
    tests++; if (StepCount !== 16'h0000) begin fails++; $display("FAIL wrap_zero got %h want 0000", StepCount); end
  endtask

  task automatic test_reset_mid_run();
    RunMode = 1'b0; RunPeriod = 16'd5;
    tick();
    RunMode = 1'b1;
    tick(); tick();
    Reset = 1'b1;
    tick();
    tests++; if (StepEn !== 1'b0) begin fails++; $display("FAIL rst_run_stepen got %0b want 0", StepEn); end
    tests++; if (StepCount !== 16'd0) begin fails++; $display("FAIL rst_run_count got %h want 0000", StepCount); end
    Reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests++; if (StepEn !== (k == 5)) begin fails++; $display("FAIL rst_run k=%0d got %0b want %0b", k, StepEn, k == 5); end
    end
  endtask

  task automatic test_random();
    int run_left = 0;
    RunMode = 1'b0; Freeze = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      if (run_left == 0) begin
        StepKey = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 10);
      end
      run_left--;
      if ($urandom_range(0, 60) == 0) RunMode = ~RunMode;
      if ($urandom_range(0, 40) == 0) RunPeriod = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 8) == 0) Freeze = ~Freeze;
      if ($urandom_range(0, 3) == 0) Sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) ChanData[$urandom_range(0, 7)*16 +: 16] = 16'($urandom);
      Reset = ($urandom_range(0, 400) == 0);
      tick();
      tests++; if (StepEn !== m_step) begin fails++; $display("FAIL rnd_stepen c=%0d got %0b want %0b", c, StepEn, m_step); end
      tests++; if (StepCount !== 16'(m_count)) begin fails++; $display("FAIL rnd_count c=%0d got %h want %h", c, StepCount, 16'(m_count)); end
      tests++; if (Digits !== {16'd0, m_disp}) begin fails++; $display("FAIL rnd_digits c=%0d got %h want %h", c, Digits, {16'd0, m_disp}); end
    end
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i <= F; i++) hist[i] = 1'b1;
    test_reset();
    test_glitch();
    test_single_step();
    test_free_run();
    test_display();
    test_reset_mid_run();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_debug_ctrl.md
# step_debug_ctrl

Board-level debug controller that drives the processor in single-step or free-run mode and selects one of several internal buses for the hex displays. It replaces the fixed button-sync/filter/mux chain with one parametrised block. It takes a raw push-button, synchronises and debounces it, and issues one-cycle step enables. It also counts steps and presents a freezable snapshot of a selected channel as hex nibbles for the segment decoders.

## Interface
- WIDTH, 16: bits per debug channel.
- CHANNELS, 8: number of selectable channels (≥2).
- DIGITS, 8: hex nibbles output.
- FILTER_CYCLES, 16: consecutive stable cycles required to accept a key level change (≥2).
- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  synchronous, active-high; one clock; overrides all other inputs.
- StepKey  in  1  raw push-button, active-low (0 = pressed), asynchronous to Clock.
- RunMode  in  1  0 = single-step from key, 1 = free-run.
- RunPeriod  in  16  free-run step period in cycles; 0 treated as 1.
- Sel  in  $clog2(CHANNELS)  channel select.
- Freeze  in  1  1 = hold displayed value.
- ChanData  in  CHANNELS*WIDTH  flattened channels; channel k = ChanData[k*WIDTH +: WIDTH].
- StepEn  out  1  one-cycle step pulse (processor clock enable).
- StepCount  out  16  steps issued since reset.
- Digits  out  DIGITS*4  nibble k = Digits[4k+3:4k].

## Operation
- Synchroniser: two flops on StepKey, both reset to 1 (released).
- Debounce: `filt` reset to 1. Counter `dcnt` clears whenever sync output equals `filt`. Otherwise it increments. When it reaches FILTER_CYCLES-1 while still differing, `filt` takes the sync value and `dcnt` clears. Any glitch shorter than FILTER_CYCLES is rejected.
- Single-step (RunMode=0): StepEn pulses for exactly one cycle on the `filt` 1→0 transition. A release produces no pulse. Holding the key produces exactly one pulse.
- Free-run (RunMode=1): key ignored for stepping; the debounce path still runs.
  - Period counter `pcnt` counts 0..P-1, with P = max(RunPeriod,1).
  - StepEn pulses in the cycle `pcnt` = P-1; `pcnt` then wraps to 0.
  - P=1 gives StepEn high every cycle.
  - `pcnt` is held at 0 while RunMode=0.
  - If RunPeriod changes so that `pcnt` ≥ new P-1, the next cycle pulses and wraps.
- Mode change: the RunMode 0→1 edge starts counting from `pcnt`=0. The 1→0 edge clears `pcnt`. A key edge completing on the same cycle as a 1→0 change is honoured only if RunMode=0 in that cycle.
- StepCount increments on every StepEn cycle and wraps 0xFFFF→0x0000.
- Display register `disp` (WIDTH bits):
  - When Freeze=0, it loads the selected channel each cycle. Sel ≥ CHANNELS loads 0.
  - When Freeze=1, it holds.
- Digits nibble k = `disp[4k+3:4k]` for 4k < WIDTH. Nibbles beyond WIDTH are 0. A partial top nibble is zero-extended. If WIDTH > 4*DIGITS, only the low 4*DIGITS bits are shown.

## Timing
- Reset values: StepEn 0, StepCount 0, Digits 0, `filt` 1, sync flops 1, `dcnt` 0, `pcnt` 0, `disp` 0.
- Reset asserted mid-count or mid-press: all state returns to reset values at the next edge. A key still held after Reset deasserts must pass the full debounce and then pulses once.
- Key latency: StepKey low and stable from the edge at cycle t gives `filt`=0 and StepEn=1 during cycle t+1+FILTER_CYCLES. StepEn is 0 in the next cycle.
- Free-run: the first pulse occurs P cycles after the first cycle with RunMode=1. After that, pulses are exactly P cycles apart.
- StepCount updates one cycle after its StepEn cycle, i.e. it is registered alongside the pulse.
- Display latency: one cycle from ChanData/Sel change to Digits. Freeze is sampled at the edge. A value captured at the edge where Freeze is first 1 is not taken; the previous value holds.

## Test plan
- Reset, FILTER_CYCLES=4, StepKey low for 3 cycles then high → no StepEn; StepCount 0.
- StepKey low for 20 cycles, RunMode=0 → exactly one StepEn pulse at cycle t+5; StepCount 1; release → no pulse.
- RunMode=1, RunPeriod=3 for 12 cycles → StepEn at cycles 3,6,9,12 after entry; StepCount 4. RunPeriod=0 → StepEn every cycle.
- WIDTH=16, CHANNELS=8:
  - ChanData ch5=0xBEEF, Sel=5 → Digits low nibbles F,E,E,B one cycle later, upper nibbles 0.
  - Freeze=1, ch5→0x1234 → Digits stay 0xBEEF.
  - Sel=7 (a valid channel) → no change while frozen.
- Force StepCount to 0xFFFF via 65535 free-run pulses at P=1, then one more → 0x0000.
- Reset asserted mid free-run (pcnt=2, P=5) → StepEn 0, pcnt 0. Next pulse 5 cycles after Reset deasserts with RunMode=1.
